// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared types and helpers for the carry-save resolver
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } csa_state_t;

    // Number of chunk steps needed to resolve a full operand.
    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Legal geometry: positive chunk that tiles the operand exactly.
    function automatic bit chunk_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// rtl/csa_chunk_adder.sv - combinational CHUNK-bit ripple adder built from full-adder cells
module csa_chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    // One full-adder cell per bit; the ripple is only CHUNK deep.
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/csa_resolver.sv
// rtl/csa_resolver.sv - resolves a carry-save pair into a binary sum CHUNK bits per clock
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             busy
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

    if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_geometry
        $error("csa_resolver: WIDTH must be a positive multiple of CHUNK");
    end

    csa_state_t       state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             c_q, c_d;
    logic [WIDTH:0]   result_q, result_d;

    logic             accept;
    int               base;
    logic [CHUNK-1:0] ch_s;
    logic             ch_cout;

    assign in_ready  = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == RUN);
    assign result    = result_q;
    assign base      = int'(idx_q) * CHUNK;

    csa_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (sum_q[base +: CHUNK]),
        .b    (carry_q[base +: CHUNK]),
        .cin  (c_q),
        .s    (ch_s),
        .cout (ch_cout)
    );

    // Next-state: step one chunk per RUN cycle, hold the result until taken, reload on accept.
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        c_d      = c_q;
        result_d = result_q;

        case (state_q)
            IDLE: ;
            RUN: begin
                result_d[base +: CHUNK] = ch_s;
                c_d = ch_cout;
                if (idx_q == IDX_LAST) begin
                    result_d[WIDTH] = ch_cout;
                    state_d         = HOLD;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept only fires in IDLE or in HOLD while the result is being taken.
        if (accept) begin
            sum_d   = in_sum;
            carry_d = in_carry;
            idx_d   = '0;
            c_d     = 1'b0;
            state_d = RUN;
        end
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sum_q    <= '0;
            carry_q  <= '0;
            idx_q    <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            c_q      <= c_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_csa_resolver.sv
// tb/tb_csa_resolver.sv - scoreboard bench for csa_resolver (CHUNK=4 and CHUNK=16 builds)
module tb_csa_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_sum;
    logic [15:0] in_carry;
    logic        out_ready;
    logic        sel = 1'b0;

    logic        in_valid_a, in_ready_a, out_valid_a, busy_a;
    logic [16:0] result_a;
    logic        in_valid_b, in_ready_b, out_valid_b, busy_b;
    logic [16:0] result_b;

    logic        ir_m, ov_m, busy_m;
    logic [16:0] res_m;

    typedef struct {
        logic [16:0] exp;
        int          acc;
    } item_t;

    item_t q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    bit    ov_prev = 1'b0;

    always #5 clk = ~clk;

    assign in_valid_a = in_valid & ~sel;
    assign in_valid_b = in_valid & sel;
    assign ir_m   = sel ? in_ready_b  : in_ready_a;
    assign ov_m   = sel ? out_valid_b : out_valid_a;
    assign busy_m = sel ? busy_b      : busy_a;
    assign res_m  = sel ? result_b    : result_a;

    csa_resolver #(.WIDTH(16), .CHUNK(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .result    (result_a),
        .busy      (busy_a)
    );

    csa_resolver #(.WIDTH(16), .CHUNK(16)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .result    (result_b),
        .busy      (busy_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair until accepted; the expected result goes to the scoreboard.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] exp,
                        input bit rand_bp, output int waits);
        item_t it;
        waits    = 0;
        in_sum   = a;
        in_carry = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (ir_m) begin
                it.exp = exp;
                it.acc = cyc + 1;
                q.push_back(it);
                break;
            end
            waits++;
            if (waits > 200) begin
                check("send_timeout", 32'(waits), 32'd0);
                break;
            end
            tick;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
        tick;
        in_valid = 1'b0;
        in_sum   = 16'($urandom);
        in_carry = 16'($urandom);
    endtask

    task automatic drain;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) tick;
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    // Monitor: latency on each new out_valid, result compare on each handshake.
    always @(negedge clk) begin
        item_t e;
        if (!rst) begin
            if (ov_m && !ov_prev) begin
                if (q.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
                else check("latency", 32'(cyc - q[0].acc), sel ? 32'd1 : 32'd4);
            end
            if (ov_m && out_ready && q.size() != 0) begin
                e = q.pop_front();
                check("result", 32'(res_m), 32'(e.exp));
            end
        end
        ov_prev = ov_m && !rst;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [15:0] a, b;

        rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = '0; out_ready = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        @(negedge clk);
        check("reset_result_a", 32'(result_a), 32'd0);
        check("reset_out_valid_a", 32'(out_valid_a), 32'd0);
        check("reset_busy_a", 32'(busy_a), 32'd0);
        check("reset_in_ready_a", 32'(in_ready_a), 32'd1);
        check("reset_out_valid_b", 32'(out_valid_b), 32'd0);
        check("reset_in_ready_b", 32'(in_ready_b), 32'd1);
        tick;

        // Directed values, sent back to back
        send(16'h1234, 16'h0FF0, 17'h02224, 1'b0, w);
        send(16'hFFFF, 16'h0001, 17'h10000, 1'b0, w);
        send(16'hFFFF, 16'hFFFF, 17'h1FFFE, 1'b0, w);
        drain();

        // Backpressure: result held for 10 cycles, then same-cycle release and accept
        out_ready = 1'b0;
        send(16'h0F0F, 16'h00F1, 17'h01000, 1'b0, w);
        for (int i = 0; i < 20 && !ov_m; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 32'(ov_m), 32'd1);
            check("bp_in_ready", 32'(ir_m), 32'd0);
            check("bp_result", 32'(res_m), 32'h01000);
            tick;
            @(negedge clk);
        end
        tick;
        out_ready = 1'b1;
        send(16'h2222, 16'h3333, 17'h05555, 1'b0, w);
        check("bp_same_cycle_accept", 32'(w), 32'd0);
        drain();

        // Reset during the second RUN cycle discards the operation
        send(16'h4321, 16'h1234, 17'h05555, 1'b0, w);
        @(negedge clk);
        check("midrun_busy", 32'(busy_m), 32'd1);
        tick;
        rst = 1'b1;
        q.delete();
        tick;
        rst = 1'b0;
        @(negedge clk);
        check("midrun_busy_cleared", 32'(busy_m), 32'd0);
        check("midrun_out_valid", 32'(ov_m), 32'd0);
        check("midrun_result", 32'(res_m), 32'd0);
        check("midrun_in_ready", 32'(ir_m), 32'd1);
        repeat (8) tick;
        @(negedge clk);
        check("midrun_no_stale", 32'(ov_m), 32'd0);
        tick;

        // Random sweep with random backpressure, CHUNK=4
        for (int n = 0; n < 1000; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            send(a, b, {1'b0, a} + {1'b0, b}, 1'b1, w);
            repeat ($urandom_range(0, 2)) tick;
        end
        drain();

        // CHUNK=16 build
        sel = 1'b1;
        tick;
        send(16'hABCD, 16'h1111, 17'h0BCDE, 1'b0, w);
        drain();
        for (int n = 0; n < 200; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            send(a, b, {1'b0, a} + {1'b0, b}, 1'b1, w);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
